// File: rtl/weight_bank_array_if.sv
// Command/response bundle for weight_bank_array.
// The master issues commands; the slave returns read responses.
interface weight_bank_array_if #(
    parameter int DATA_W = 16
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [31:0]       cmd_addr;
    logic [31:0]       cmd_data;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic [9:0]        rd_bank;
    logic              rd_last;

    modport master (
        output cmd_valid, cmd_addr, cmd_data,
        input  cmd_ready, rd_valid, rd_data, rd_bank, rd_last
    );

    modport slave (
        input  cmd_valid, cmd_addr, cmd_data,
        output cmd_ready, rd_valid, rd_data, rd_bank, rd_last
    );
endinterface

// File: rtl/weight_bank_array.sv
// Banked weight/activation RAM with broadcast write, gather read,
// tagged responses and a sticky error flag for bad commands.
module weight_bank_array #(
    parameter int NUM_BANKS = 2,
    parameter int DATA_W    = 16,
    parameter int DEPTH     = 1024,
    parameter int AW        = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    weight_bank_array_if.slave   bus,
    output logic                 err,
    input  logic                 err_clr
);
    typedef enum logic {IDLE, GATHER} state_t;

    state_t                state_q, state_d;
    logic [9:0]            cnt_q, cnt_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic [DATA_W-1:0]     data_q, data_d;
    logic [NUM_BANKS-1:0]  wren_q, wren_d;
    logic                  rvld_q, rvld_d;
    logic [9:0]            rbank_q, rbank_d;
    logic                  rlast_q, rlast_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0]     rd_data_q, rd_data_d;
    logic [9:0]            rd_bank_q, rd_bank_d;
    logic                  rd_last_q, rd_last_d;
    logic                  err_q, err_d;

    logic [19:0]           word;
    logic [9:0]            bank;
    logic                  is_gth, is_we;
    logic                  addr_ok, bank_ok, bcast;
    logic                  accept;
    logic [DATA_W-1:0]     rd_word [NUM_BANKS];
    logic                  unused_data;

    assign word    = bus.cmd_addr[19:0];
    assign bank    = bus.cmd_addr[29:20];
    assign is_gth  = bus.cmd_addr[31];
    assign is_we   = bus.cmd_addr[30];
    assign addr_ok = 32'(word) < 32'(DEPTH);
    assign bank_ok = 32'(bank) < 32'(NUM_BANKS);
    assign bcast   = bank == 10'h3FF;
    assign accept  = bus.cmd_valid && bus.cmd_ready;
    assign unused_data = ^bus.cmd_data;

    assign bus.cmd_ready = state_q == IDLE;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.rd_bank   = rd_bank_q;
    assign bus.rd_last   = rd_last_q;
    assign err           = err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wren_d  = '0;
        rvld_d  = 1'b0;
        rbank_d = rbank_q;
        rlast_d = rlast_q;
        err_d   = err_q & ~err_clr;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!addr_ok) begin
                        err_d = 1'b1;
                    end else if (is_gth) begin
                        addr_d  = word[AW-1:0];
                        rvld_d  = 1'b1;
                        rbank_d = 10'd0;
                        rlast_d = NUM_BANKS == 1;
                        if (NUM_BANKS > 1) begin
                            state_d = GATHER;
                            cnt_d   = 10'd1;
                        end
                    end else if (is_we) begin
                        addr_d = word[AW-1:0];
                        data_d = bus.cmd_data[DATA_W-1:0];
                        if (bcast) begin
                            wren_d = '1;
                        end else if (bank_ok) begin
                            for (int b = 0; b < NUM_BANKS; b++)
                                if (bank == 10'(b)) wren_d[b] = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (bank_ok) begin
                        addr_d  = word[AW-1:0];
                        rvld_d  = 1'b1;
                        rbank_d = bank;
                        rlast_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            GATHER: begin
                // addr_q still holds the gather address
                rvld_d  = 1'b1;
                rbank_d = cnt_q;
                rlast_d = cnt_q == 10'(NUM_BANKS - 1);
                cnt_d   = cnt_q + 10'd1;
                if (cnt_q == 10'(NUM_BANKS - 1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_valid_d = rvld_q;
        rd_data_d  = rd_data_q;
        rd_bank_d  = rd_bank_q;
        rd_last_d  = rd_last_q;
        if (rvld_q) begin
            rd_bank_d = rbank_q;
            rd_last_d = rlast_q;
            for (int b = 0; b < NUM_BANKS; b++)
                if (rbank_q == 10'(b)) rd_data_d = rd_word[b];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            wren_q     <= '0;
            rvld_q     <= 1'b0;
            rbank_q    <= '0;
            rlast_q    <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_bank_q  <= '0;
            rd_last_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            wren_q     <= wren_d;
            rvld_q     <= rvld_d;
            rbank_q    <= rbank_d;
            rlast_q    <= rlast_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            rd_bank_q  <= rd_bank_d;
            rd_last_q  <= rd_last_d;
            err_q      <= err_d;
        end
    end

    // RAM contents deliberately survive reset
    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        logic [DATA_W-1:0] mem [DEPTH];
        always_ff @(posedge clk) begin
            if (wren_q[g]) mem[addr_q] <= data_q;
        end
        assign rd_word[g] = mem[addr_q];
    end
endmodule
